// File: rtl/train_pkg.sv
// Shared encodings and helpers for the train segment sequencer.
package train_pkg;

  localparam int NUM_SEG = 6;

  typedef logic [1:0]         state_t;
  typedef logic [NUM_SEG-1:0] sensor_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [2:0] SEG_NONE  = 3'd0;
  localparam logic [2:0] SEG_FIRST = 3'd1;
  localparam logic [3:0] BCD_FAULT = 4'hF;
  localparam sensor_t    S1_MASK   = sensor_t'(1);

  // Segment after idx, wrapping the last segment back to the first.
  function automatic logic [2:0] next_seg(input logic [2:0] idx);
    return (idx == 3'(NUM_SEG)) ? SEG_FIRST : idx + 3'd1;
  endfunction

  // One-hot sensor mask of the sensor that opens segment idx (none for idle).
  function automatic sensor_t seg_mask(input logic [2:0] idx);
    return (idx == SEG_NONE) ? '0 : sensor_t'(1) << (idx - 3'd1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Timing tick divider: counts 0..TICK_DIV-1 while clr is low; tick flags the wrap cycle.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/train_sequencer.sv
// Six-sensor lap sequencer: tracks the current segment, times each segment in ticks
// and flags out-of-order sensors or segment timeouts.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for the first S1 rise after reset
//   ST_RUN   | timing segment seg_idx, expecting sensor seg_idx+1 (6->1)
//   ST_FAULT | sequence or timeout error; fault held until S1 rises alone
module train_sequencer
  import train_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int TMAX     = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] s_in,
  output logic       seg_ld,
  output logic       seg_en,
  output logic [2:0] seg_idx,
  output logic [7:0] seg_time,
  output logic       time_valid,
  output logic [3:0] bcd,
  output logic       fault
);

  localparam logic [7:0] TMAX_V = 8'(TMAX);

  state_t     state;
  state_t     state_nx;
  sensor_t    s_prev;
  sensor_t    armed;
  sensor_t    rise;
  sensor_t    own_mask;
  sensor_t    exp_mask;
  logic       tick;
  logic       clr;
  logic [7:0] elapsed;
  logic [7:0] elapsed_nx;
  logic [7:0] elapsed_inc;
  logic [7:0] seg_time_nx;
  logic [2:0] idx_nx;
  logic       ld_nx;
  logic       en_nx;
  logic       tv_nx;

  // armed keeps a sensor that was already high at reset release from counting as a rise.
  assign rise        = s_in & ~s_prev & armed;
  assign own_mask    = seg_mask(seg_idx);
  assign exp_mask    = seg_mask(next_seg(seg_idx));
  assign elapsed_inc = (elapsed < TMAX_V) ? elapsed + 8'd1 : elapsed;
  assign clr         = (state != ST_RUN) || ld_nx;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    state_nx    = state;
    idx_nx      = seg_idx;
    elapsed_nx  = elapsed;
    seg_time_nx = seg_time;
    ld_nx       = 1'b0;
    en_nx       = 1'b0;
    tv_nx       = 1'b0;
    case (state)
      ST_IDLE, ST_FAULT: begin
        if (rise == S1_MASK) begin
          state_nx   = ST_RUN;
          idx_nx     = SEG_FIRST;
          elapsed_nx = '0;
          ld_nx      = 1'b1;
        end
      end
      ST_RUN: begin
        if (rise == exp_mask) begin
          // A tick landing on the closing edge still belongs to this segment.
          seg_time_nx = tick ? elapsed_inc : elapsed;
          tv_nx       = 1'b1;
          ld_nx       = 1'b1;
          idx_nx      = next_seg(seg_idx);
          elapsed_nx  = '0;
        end else if (rise != '0 && rise != own_mask) begin
          state_nx = ST_FAULT;
        end else if (tick) begin
          if (elapsed == TMAX_V) begin
            state_nx = ST_FAULT;
          end else begin
            elapsed_nx = elapsed_inc;
            en_nx      = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      s_prev     <= '0;
      armed      <= '0;
      elapsed    <= '0;
      seg_idx    <= SEG_NONE;
      seg_time   <= '0;
      seg_ld     <= 1'b0;
      seg_en     <= 1'b0;
      time_valid <= 1'b0;
      bcd        <= '0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nx;
      s_prev     <= s_in;
      armed      <= armed | ~s_in;
      elapsed    <= elapsed_nx;
      seg_idx    <= idx_nx;
      seg_time   <= seg_time_nx;
      seg_ld     <= ld_nx;
      seg_en     <= en_nx;
      time_valid <= tv_nx;
      fault      <= (state_nx == ST_FAULT);
      bcd        <= (state_nx == ST_FAULT) ? BCD_FAULT : {1'b0, idx_nx};
    end
  end

endmodule

// File: tb/tb_train_sequencer.sv
// Bench for train_sequencer: directed scenarios plus randomized sensor traffic
// checked every cycle against a segment-timing reference model.
module tb_train_sequencer;

  localparam int TICK_DIV = 4;
  localparam int TMAX     = 10;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_FAULT  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] s_in = '0;
  logic       seg_ld;
  logic       seg_en;
  logic [2:0] seg_idx;
  logic [7:0] seg_time;
  logic       time_valid;
  logic [3:0] bcd;
  logic       fault;

  always #5 clk = ~clk;

  train_sequencer #(
    .TICK_DIV(TICK_DIV),
    .TMAX    (TMAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_in      (s_in),
    .seg_ld    (seg_ld),
    .seg_en    (seg_en),
    .seg_idx   (seg_idx),
    .seg_time  (seg_time),
    .time_valid(time_valid),
    .bcd       (bcd),
    .fault     (fault)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int tv_seen = 0;

  // Reference model: segment number, clocks since the segment opened, last segment time.
  int         m_state;
  int         m_idx;
  int         m_c;
  int         m_time;
  logic [5:0] m_prev;
  logic [5:0] m_armed;
  bit         e_ld;
  bit         e_en;
  bit         e_tv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_idx   = 0;
    m_c     = 0;
    m_time  = 0;
    m_prev  = '0;
    m_armed = '0;
    e_ld    = 0;
    e_en    = 0;
    e_tv    = 0;
  endtask

  task automatic model_step(input logic [5:0] s);
    logic [5:0] rise;
    logic [5:0] own;
    logic [5:0] expm;
    int         nxt;
    rise    = s & ~m_prev & m_armed;
    m_armed = m_armed | ~s;
    m_prev  = s;
    e_ld = 0;
    e_en = 0;
    e_tv = 0;
    if (m_state == M_RUN) begin
      m_c++;
      nxt  = (m_idx == 6) ? 1 : m_idx + 1;
      own  = 6'(1) << (m_idx - 1);
      expm = 6'(1) << (nxt - 1);
      if (rise == expm) begin
        m_time = (m_c / TICK_DIV > TMAX) ? TMAX : m_c / TICK_DIV;
        e_tv   = 1;
        e_ld   = 1;
        m_idx  = nxt;
        m_c    = 0;
      end else if (rise != 0 && rise != own) begin
        m_state = M_FAULT;
      end else if (m_c % TICK_DIV == 0) begin
        if (m_c / TICK_DIV > TMAX) m_state = M_FAULT;
        else e_en = 1;
      end
    end else if (rise == 6'b000001) begin
      m_state = M_RUN;
      m_idx   = 1;
      m_c     = 0;
      e_ld    = 1;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".seg_idx"}, 32'(seg_idx), 32'(m_idx));
    chk({ctx, ".fault"}, 32'(fault), (m_state == M_FAULT) ? 32'd1 : 32'd0);
    chk({ctx, ".bcd"}, 32'(bcd), (m_state == M_FAULT) ? 32'd15 : 32'(m_idx));
    chk({ctx, ".seg_ld"}, 32'(seg_ld), 32'(e_ld));
    chk({ctx, ".seg_en"}, 32'(seg_en), 32'(e_en));
    chk({ctx, ".time_valid"}, 32'(time_valid), 32'(e_tv));
    chk({ctx, ".seg_time"}, 32'(seg_time), 32'(m_time));
  endtask

  // Called at a falling edge: apply inputs, clock once, check at the next falling edge.
  task automatic step(input logic [5:0] s, input string ctx);
    s_in = s;
    model_step(s);
    @(posedge clk);
    @(negedge clk);
    if (time_valid) tv_seen++;
    check_all(ctx);
  endtask

  initial begin
    logic [5:0] s;
    int         nx;
    int         rate;

    model_reset();
    rst_n = 1'b0;
    s_in  = '0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    step('0, "idle");
    step('0, "idle");

    // Segment timing: S2 sampled 40 clocks after S1 closes segment 1 at 10 ticks.
    step(6'b000001, "s1_start");
    repeat (39) step('0, "seg1");
    tv_seen = 0;
    step(6'b000010, "s2_close");
    chk("timing.seg_time", 32'(seg_time), 32'd10);
    chk("timing.time_valid", 32'(time_valid), 32'd1);
    chk("timing.seg_idx", 32'(seg_idx), 32'd2);
    chk("timing.seg_ld", 32'(seg_ld), 32'd1);
    step(6'b000010, "after_close");
    chk("timing.tv_one_cycle", 32'(time_valid), 32'd0);

    // Lap wrap: S3..S6 then S1.
    for (int k = 3; k <= 6; k++) begin
      repeat (3) step('0, "lap_gap");
      step(6'(1) << (k - 1), "lap_sensor");
    end
    chk("lap.idx6", 32'(seg_idx), 32'd6);
    repeat (3) step('0, "lap_gap");
    step(6'b000001, "lap_wrap");
    chk("lap.idx_wrap", 32'(seg_idx), 32'd1);
    chk("lap.tv_count", 32'(tv_seen), 32'd6);
    chk("lap.no_fault", 32'(fault), 32'd0);

    // Sequence fault from segment 2, then recovery on S1.
    repeat (3) step('0, "seq_gap");
    step(6'b000010, "seq_s2");
    step('0, "seq_gap");
    step(6'b001000, "seq_s4");
    chk("seq.fault", 32'(fault), 32'd1);
    chk("seq.bcd", 32'(bcd), 32'hF);
    chk("seq.idx_hold", 32'(seg_idx), 32'd2);
    step('0, "seq_gap");
    step(6'b000001, "seq_recover");
    chk("seq.recover_fault", 32'(fault), 32'd0);
    chk("seq.recover_idx", 32'(seg_idx), 32'd1);

    // Timeout: 44 quiet clocks in segment 1.
    repeat (43) step('0, "quiet");
    chk("timeout.not_yet", 32'(fault), 32'd0);
    step('0, "quiet");
    chk("timeout.fault", 32'(fault), 32'd1);

    // Simultaneous S1+S2 from segment 1.
    step(6'b000001, "sim_start");
    step('0, "sim_gap");
    step(6'b000011, "sim_both");
    chk("simul.fault", 32'(fault), 32'd1);

    // Reset mid-run in segment 3, with S1 held high through release.
    step('0, "mid_gap");
    step(6'b000001, "mid_s1");
    step('0, "mid_gap");
    step(6'b000010, "mid_s2");
    step('0, "mid_gap");
    step(6'b000100, "mid_s3");
    chk("midrst.idx3", 32'(seg_idx), 32'd3);
    s_in  = 6'b000001;
    rst_n = 1'b0;
    #1;
    chk("midrst.idx", 32'(seg_idx), 32'd0);
    chk("midrst.bcd", 32'(bcd), 32'd0);
    chk("midrst.seg_time", 32'(seg_time), 32'd0);
    chk("midrst.strobes", 32'({seg_ld, seg_en, time_valid, fault}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(6'b000001, "held_s1");
    chk("midrst.no_start", 32'(seg_idx), 32'd0);

    // Randomized sensor traffic, biased toward the sensor the model expects next.
    for (int blk = 0; blk < 8; blk++) begin
      rate = (blk % 4 == 3) ? 80 : int'($urandom_range(4, 24));
      for (int cyc = 0; cyc < 500; cyc++) begin
        s = s_in;
        for (int b = 0; b < 6; b++)
          if ($urandom_range(0, 3) == 0) s = s & ~(6'(1) << b);
        if (m_state == M_RUN) begin
          nx = (m_idx == 6) ? 1 : m_idx + 1;
          if ($urandom_range(0, rate) == 0) s = s | (6'(1) << (nx - 1));
          if ($urandom_range(0, 40) == 0) s = s | (6'(1) << (m_idx - 1));
        end else if ($urandom_range(0, 10) == 0) begin
          s = s | 6'b000001;
        end
        if ($urandom_range(0, 150) == 0) s = s | (6'(1) << $urandom_range(0, 5));
        step(s, "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
